bridge_reg_bank: RTL and testbench
==================================

Name: bridge_reg_bank

Overview:
Parametrised bank of NUM_REGS bridge-mapped 32-bit configuration registers. It generalises the single hard-coded dip-switch register into a reusable block with per-register reset values and write masks, double buffering (shadow/live) and a commit/discard mechanism. It sits between the bridge leaf and core logic. The core sees only live values, which change atomically on an apply strobe (e.g. vblank or unpause) or on a forced commit.

Parameters:
BASE_ADDR, 32'h00100000, byte address of register 0; must be 512-byte aligned
NUM_REGS, 4, number of registers, 1..64
RESET_VALS, all 0, array [NUM_REGS] of 32-bit reset/power-on values
WR_MASKS, all 32'hffffffff, array [NUM_REGS]; 1 = bit writable
GATED, 1, 1 = shadow→live only on commit; 0 = live follows shadow one cycle after a write

Ports:
clk_74a  in  1  bridge clock; sole clock
reset_n  in  1  asynchronous, active-low reset
bridge_addr  in  32  bridge address
bridge_wr  in  1  write strobe, one cycle per access
bridge_wr_data  in  32  write data
bridge_rd  in  1  read strobe (informational; reads have no side effects)
bridge_rd_data  out  32  registered read data
bridge_selected  out  1  combinational: address is inside this block's window
apply_strobe  in  1  single-cycle commit request from core
regs_live  out  NUM_REGS*32  live register values; reg i at [32*i +: 32]
reg_updated  out  NUM_REGS  one-cycle pulse per register whose live value changed
pending  out  1  shadow differs from live as a result of writes not yet committed

Behaviour:
- Window: BASE_ADDR .. BASE_ADDR+0x103. Register i is at BASE+4*i. CTRL is at BASE+0x100. Address bits [1:0] are ignored.
- bridge_selected = address inside the window (combinational).
- Register write: shadow[i] <= (wr_data & WR_MASKS[i]) | (RESET_VALS[i] & ~WR_MASKS[i]). Writes to index >= NUM_REGS below CTRL are dropped.
- With GATED=1, a register write sets pending on the next edge.
- Reads: bridge_rd_data is registered every cycle from the current address, with 1-cycle latency. Register i returns shadow[i]. CTRL returns {16'b0, apply_count[7:0], 7'b0, pending}. Unmapped addresses in the window return 0. Outside the window the output is don't-care and returns 0.
- CTRL write:
  - bit0 = force commit.
  - bit1 = discard (shadow <= live, pending <= 0, no reg_updated pulses).
- Commit event (apply_strobe, or CTRL bit0 write) with pending=1:
  - live <= shadow.
  - pending <= 0.
  - apply_count increments, wrapping 255→0.
  - reg_updated[i] pulses in the following cycle for each i where the old live differs from the new live.
- Commit with pending=0: no effect, and apply_count is unchanged.
- Simultaneous events:
  - Register write plus commit in the same cycle: the commit uses the pre-write shadow. The write lands in shadow and pending stays 1.
  - Discard plus commit in the same cycle (both CTRL bits, or CTRL discard plus apply_strobe): discard wins.
  - Discard plus register write cannot coincide (one bridge access per cycle).
- GATED=0:
  - live <= shadow on the cycle after each write; reg_updated pulses if the value changed.
  - pending is always 0.
  - apply_strobe and CTRL bit0 are ignored; discard has no effect.
- Reset, asynchronous including mid-operation:
  - shadow = live = RESET_VALS.
  - pending = 0, apply_count = 0.
  - reg_updated = 0, bridge_rd_data = 0.
  - No reg_updated pulse is generated on reset release.

Decomposition:
- Package jailbreak gets:
  - REG_BANK_CTRL_OFFSET = 'h100.
  - reg_bank_ctrl_t: packed struct with pending, reserved, apply_count.
  - reg_bank_ctrl_wr_t: commit and discard bits.
- Sub-module bridge_reg_cell: one shadow/live pair with mask/reset-value parameters, write/commit/discard inputs, and changed-pulse output. It is instantiated NUM_REGS times by a generate loop.
- The top level holds the address decode, CTRL register, pending flag and read mux.

Test Plan:
- Reset with RESET_VALS={1,2,3,4}, then read BASE+0x8 → rd_data=3 one cycle later; regs_live reg2=3; pending=0; no reg_updated pulse.
- GATED=1: write 0xDEADBEEF to BASE+0x4 with WR_MASKS[1]=0x0000FFFF and RESET_VALS[1]=2 → shadow reads 0x0000BEEF, live unchanged, pending=1. Pulse apply_strobe → live=0x0000BEEF, reg_updated=0b0010 for one cycle, CTRL reads 0x00000100.
- Write BASE+0x0 in the same cycle as apply_strobe, with reg1 pending → reg1 commits, reg0 stays in shadow only, pending stays 1. A second strobe commits reg0, and apply_count becomes 2.
- Write shadow, then write CTRL=0x3 → discard wins: shadow reverts to live, pending=0, apply_count unchanged, no pulses.
- Do 256 commits → apply_count wraps to 0. Rewrite an identical value and commit → count increments but no reg_updated pulse.
- GATED=0: write 0x55 to BASE+0xC → live reg3=0x55 on the next edge with a reg_updated[3] pulse. Assert reset_n low mid-sequence → all values are RESET_VALS immediately.

Source files
------------

// File: rtl/bridge_reg_bank_pkg.sv
// Shared types and helpers for the bridge-mapped configuration register bank.
package bridge_reg_bank_pkg;

    localparam logic [8:0] REG_BANK_CTRL_OFFSET = 9'h100;

    // Read view of the CTRL word: {16'b0, apply_count, 7'b0, pending}.
    typedef struct packed {
        logic [15:0] reserved_hi;
        logic [7:0]  apply_count;
        logic [6:0]  reserved_lo;
        logic        pending;
    } reg_bank_ctrl_t;

    // Write view of the CTRL word, low two data bits.
    typedef struct packed {
        logic discard;
        logic commit;
    } reg_bank_ctrl_wr_t;

    function automatic logic [31:0] mask_merge(
        input logic [31:0] data,
        input logic [31:0] mask,
        input logic [31:0] rval
    );
        return (data & mask) | (rval & ~mask);
    endfunction

endpackage

// File: rtl/bridge_reg_cell.sv
// One shadow/live register pair with a per-cell write mask and reset value.
module bridge_reg_cell
    import bridge_reg_bank_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter logic [31:0] WR_MASK   = 32'hffff_ffff,
    parameter bit          GATED     = 1'b1
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        discard,
    output logic [31:0] shadow,
    output logic [31:0] live,
    output logic        changed
);

    logic do_commit;
    logic do_discard;
    logic unused_ctl;

    // Ungated cells copy shadow to live every cycle, so live trails writes by one edge.
    assign do_commit  = GATED ? commit : 1'b1;
    assign do_discard = GATED && discard;
    assign unused_ctl = commit ^ discard;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= RESET_VAL;
            live    <= RESET_VAL;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (do_discard) begin
                shadow <= live;
            end else if (wr_en) begin
                shadow <= mask_merge(wr_data, WR_MASK, RESET_VAL);
            end
            if (do_commit) begin
                live    <= shadow;
                changed <= (live != shadow);
            end
        end
    end

endmodule

// File: rtl/bridge_reg_bank.sv
// Bank of bridge-mapped 32-bit registers with shadow/live double buffering,
// commit/discard control and a registered read port.
module bridge_reg_bank
    import bridge_reg_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR            = 32'h0010_0000,
    parameter int          NUM_REGS             = 4,
    parameter logic [31:0] RESET_VALS [NUM_REGS] = '{default: 32'h0},
    parameter logic [31:0] WR_MASKS   [NUM_REGS] = '{default: 32'hffff_ffff},
    parameter bit          GATED                = 1'b1
) (
    input  logic                     clk_74a,
    input  logic                     reset_n,
    input  logic [31:0]              bridge_addr,
    input  logic                     bridge_wr,
    input  logic [31:0]              bridge_wr_data,
    input  logic                     bridge_rd,
    output logic [31:0]              bridge_rd_data,
    output logic                     bridge_selected,
    input  logic                     apply_strobe,
    output logic [NUM_REGS*32-1:0]   regs_live,
    output logic [NUM_REGS-1:0]      reg_updated,
    output logic                     pending
);

    logic              in_window;
    logic              is_reg;
    logic              is_ctrl;
    logic [5:0]        word;
    logic              reg_wr;
    logic              ctrl_wr;
    logic              discard_evt;
    logic              commit_evt;
    logic [7:0]        apply_count;
    reg_bank_ctrl_wr_t ctrl_cmd;
    reg_bank_ctrl_t    ctrl_rd;
    logic [31:0]       rd_next;
    logic [31:0]       shadow_q [NUM_REGS];
    logic [2:0]        unused_bits;

    // BASE_ADDR is 512-byte aligned, so the window is decoded from bits [31:9]
    // plus the in-page offset limit of 0x103.
    assign in_window       = (bridge_addr[31:9] == BASE_ADDR[31:9]) &&
                             (!bridge_addr[8] || (bridge_addr[7:2] == 6'd0));
    assign bridge_selected = in_window;
    assign word            = bridge_addr[7:2];
    assign is_ctrl         = in_window && (bridge_addr[8:2] == REG_BANK_CTRL_OFFSET[8:2]);
    assign is_reg          = in_window && !bridge_addr[8] && ({1'b0, word} < 7'(NUM_REGS));
    assign unused_bits     = {bridge_rd, bridge_addr[1:0]};

    assign reg_wr   = bridge_wr && is_reg;
    assign ctrl_wr  = bridge_wr && is_ctrl;
    assign ctrl_cmd = reg_bank_ctrl_wr_t'(bridge_wr_data[1:0]);

    // Discard beats any commit request arriving in the same cycle.
    assign discard_evt = GATED && ctrl_wr && ctrl_cmd.discard;
    assign commit_evt  = GATED && pending && !discard_evt &&
                         (apply_strobe || (ctrl_wr && ctrl_cmd.commit));

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        bridge_reg_cell #(
            .RESET_VAL (RESET_VALS[g]),
            .WR_MASK   (WR_MASKS[g]),
            .GATED     (GATED)
        ) u_cell (
            .clk_74a (clk_74a),
            .reset_n (reset_n),
            .wr_en   (reg_wr && (word == 6'(g))),
            .wr_data (bridge_wr_data),
            .commit  (commit_evt),
            .discard (discard_evt),
            .shadow  (shadow_q[g]),
            .live    (regs_live[32*g +: 32]),
            .changed (reg_updated[g])
        );
    end

    // A write in the same cycle as a commit keeps pending set: it lands after the copy.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= 1'b0;
            apply_count <= 8'd0;
        end else begin
            if (discard_evt) begin
                pending <= 1'b0;
            end else if (reg_wr && GATED) begin
                pending <= 1'b1;
            end else if (commit_evt) begin
                pending <= 1'b0;
            end
            if (commit_evt) begin
                apply_count <= apply_count + 8'd1;
            end
        end
    end

    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd.apply_count = apply_count;
        ctrl_rd.pending     = pending;
    end

    always_comb begin
        rd_next = 32'h0;
        if (is_ctrl) begin
            rd_next = ctrl_rd;
        end else if (is_reg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (word == 6'(i)) begin
                    rd_next = shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            bridge_rd_data <= 32'h0;
        end else begin
            bridge_rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Bench for bridge_reg_bank: one gated and one ungated instance on shared stimulus,
// checked against an array-level model of the register rules.
module tb_bridge_reg_bank;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] CTRL = BASE + 32'h100;
    localparam logic [31:0] RV [N] = '{32'd1, 32'd2, 32'd3, 32'd4};
    localparam logic [31:0] WM [N] = '{32'hffff_ffff, 32'h0000_ffff, 32'hffff_ffff, 32'hffff_0fff};

    logic              clk_74a;
    logic              reset_n;
    logic [31:0]       bridge_addr;
    logic              bridge_wr;
    logic [31:0]       bridge_wr_data;
    logic              bridge_rd;
    logic              apply_strobe;
    logic [31:0]       rd_g, rd_u;
    logic              sel_g, sel_u;
    logic [N*32-1:0]   live_g, live_u;
    logic [N-1:0]      upd_g, upd_u;
    logic              pend_g, pend_u;

    bridge_reg_bank #(
        .BASE_ADDR (BASE), .NUM_REGS (N), .RESET_VALS (RV), .WR_MASKS (WM), .GATED (1'b1)
    ) dut_g (
        .clk_74a (clk_74a), .reset_n (reset_n), .bridge_addr (bridge_addr),
        .bridge_wr (bridge_wr), .bridge_wr_data (bridge_wr_data), .bridge_rd (bridge_rd),
        .bridge_rd_data (rd_g), .bridge_selected (sel_g), .apply_strobe (apply_strobe),
        .regs_live (live_g), .reg_updated (upd_g), .pending (pend_g)
    );

    bridge_reg_bank #(
        .BASE_ADDR (BASE), .NUM_REGS (N), .RESET_VALS (RV), .WR_MASKS (WM), .GATED (1'b0)
    ) dut_u (
        .clk_74a (clk_74a), .reset_n (reset_n), .bridge_addr (bridge_addr),
        .bridge_wr (bridge_wr), .bridge_wr_data (bridge_wr_data), .bridge_rd (bridge_rd),
        .bridge_rd_data (rd_u), .bridge_selected (sel_u), .apply_strobe (apply_strobe),
        .regs_live (live_u), .reg_updated (upd_u), .pending (pend_u)
    );

    // Clock and watchdog
    initial begin
        clk_74a = 1'b0;
        forever #5 clk_74a = ~clk_74a;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model: index 1 = gated bank, index 0 = ungated bank
    logic [31:0]  m_sh [2][N];
    logic [31:0]  m_lv [2][N];
    logic         m_pend [2];
    logic [7:0]   m_cnt [2];
    logic [N-1:0] m_upd [2];
    logic [31:0]  exp_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < N; i++) begin
                m_sh[g][i] = RV[i];
                m_lv[g][i] = RV[i];
            end
            m_pend[g] = 1'b0;
            m_cnt[g]  = 8'd0;
            m_upd[g]  = '0;
        end
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s live_g[%0d]", tag, i), live_g[32*i +: 32], m_lv[1][i]);
            check($sformatf("%s live_u[%0d]", tag, i), live_u[32*i +: 32], m_lv[0][i]);
        end
        check({tag, " reg_updated_g"}, 32'(upd_g), 32'(m_upd[1]));
        check({tag, " reg_updated_u"}, 32'(upd_u), 32'(m_upd[0]));
        check({tag, " pending_g"}, 32'(pend_g), 32'(m_pend[1]));
        check({tag, " pending_u"}, 32'(pend_u), 32'(m_pend[0]));
    endtask

    // Asynchronous reset: applied mid-cycle, values checked before any clock edge.
    task automatic do_reset();
        #2;
        reset_n      = 1'b0;
        bridge_wr    = 1'b0;
        apply_strobe = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        check("async_reset rd_g", rd_g, 32'h0);
        check("async_reset rd_u", rd_u, 32'h0);
        repeat (2) @(negedge clk_74a);
        reset_n = 1'b1;
    endtask

    // Driver: one bridge cycle, starting and ending at a falling edge.
    task automatic cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic strobe);
        logic        sel, is_reg, is_ctrl, disc, creq;
        int          w;
        logic [31:0] off, wval;
        bridge_wr      = wr;
        bridge_addr    = addr;
        bridge_wr_data = data;
        bridge_rd      = ~wr;
        apply_strobe   = strobe;
        #1;
        sel     = (addr >= BASE) && (addr <= BASE + 32'h103);
        off     = addr - BASE;
        w       = int'(off >> 2);
        is_ctrl = sel && (w == 64);
        is_reg  = sel && (w < N);
        check("selected_g", 32'(sel_g), 32'(sel));
        check("selected_u", 32'(sel_u), 32'(sel));
        wval = 32'h0;
        if (is_reg) wval = (data & WM[w]) | (RV[w] & ~WM[w]);
        for (int g = 1; g >= 0; g--) begin
            if (is_ctrl)     exp_q.push_back({16'h0, m_cnt[g], 7'h0, m_pend[g]});
            else if (is_reg) exp_q.push_back(m_sh[g][w]);
            else             exp_q.push_back(32'h0);
        end
        // gated bank: discard wins, otherwise commit the old shadow then apply the write
        disc = wr && is_ctrl && data[1];
        creq = strobe || (wr && is_ctrl && data[0]);
        m_upd[1] = '0;
        if (disc) begin
            for (int i = 0; i < N; i++) m_sh[1][i] = m_lv[1][i];
            m_pend[1] = 1'b0;
        end else begin
            if (creq && m_pend[1]) begin
                for (int i = 0; i < N; i++) begin
                    m_upd[1][i] = (m_lv[1][i] != m_sh[1][i]);
                    m_lv[1][i]  = m_sh[1][i];
                end
                m_cnt[1]  = m_cnt[1] + 8'd1;
                m_pend[1] = 1'b0;
            end
            if (wr && is_reg) begin
                m_sh[1][w] = wval;
                m_pend[1]  = 1'b1;
            end
        end
        // ungated bank: live trails shadow by one cycle
        for (int i = 0; i < N; i++) begin
            m_upd[0][i] = (m_lv[0][i] != m_sh[0][i]);
            m_lv[0][i]  = m_sh[0][i];
        end
        if (wr && is_reg) m_sh[0][w] = wval;
        @(posedge clk_74a);
        @(negedge clk_74a);
        if (exp_q.size() < 2) begin
            check("scoreboard depth", 32'(exp_q.size()), 32'd2);
        end else begin
            check("rd_data_g", rd_g, exp_q.pop_front());
            check("rd_data_u", rd_u, exp_q.pop_front());
        end
        check_state("cycle");
        bridge_wr    = 1'b0;
        apply_strobe = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } rd_vec_t;

    rd_vec_t vecs [10];

    initial begin
        int pick;
        logic [31:0] a, d;
        reset_n        = 1'b0;
        bridge_addr    = 32'h0;
        bridge_wr      = 1'b0;
        bridge_wr_data = 32'h0;
        bridge_rd      = 1'b0;
        apply_strobe   = 1'b0;

        vecs[0] = '{BASE + 32'h000, 1'b1, 32'd1};
        vecs[1] = '{BASE + 32'h008, 1'b1, 32'd3};
        vecs[2] = '{BASE + 32'h00e, 1'b1, 32'd4};
        vecs[3] = '{BASE + 32'h005, 1'b1, 32'd2};
        vecs[4] = '{BASE + 32'h010, 1'b1, 32'd0};
        vecs[5] = '{BASE + 32'h0fc, 1'b1, 32'd0};
        vecs[6] = '{BASE + 32'h100, 1'b1, 32'd0};
        vecs[7] = '{BASE + 32'h103, 1'b1, 32'd0};
        vecs[8] = '{BASE + 32'h104, 1'b0, 32'd0};
        vecs[9] = '{BASE - 32'h004, 1'b0, 32'd0};

        @(negedge clk_74a);
        do_reset();

        // Address decode and reset read-back table
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, vecs[k].addr, 32'h0, 1'b0);
            check($sformatf("table[%0d] selected", k), 32'(sel_g), 32'(vecs[k].exp_sel));
            check($sformatf("table[%0d] rd_data", k), rd_g, vecs[k].exp_rd);
        end
        check("reset live reg2", live_g[64 +: 32], 32'd3);
        check("reset no pulse", 32'(upd_g), 32'h0);

        // Masked write, then apply strobe
        cycle(1'b1, BASE + 32'h4, 32'hdead_beef, 1'b0);
        cycle(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        check("masked shadow", rd_g, 32'h0000_beef);
        check("live before apply", live_g[32 +: 32], 32'd2);
        check("pending after write", 32'(pend_g), 32'd1);
        cycle(1'b0, BASE + 32'h4, 32'h0, 1'b1);
        check("live after apply", live_g[32 +: 32], 32'h0000_beef);
        check("apply pulse", 32'(upd_g), 32'b0010);
        cycle(1'b0, CTRL, 32'h0, 1'b0);
        check("ctrl after apply", rd_g, 32'h0000_0100);
        check("pulse one cycle", 32'(upd_g), 32'h0);

        // Write coinciding with a commit: commit uses pre-write shadow
        do_reset();
        cycle(1'b1, BASE + 32'h4, 32'h0000_1234, 1'b0);
        cycle(1'b1, BASE + 32'h0, 32'haaaa_5555, 1'b1);
        check("coincident reg1 live", live_g[32 +: 32], 32'h0000_1234);
        check("coincident reg0 live", live_g[0 +: 32], 32'd1);
        check("coincident pending", 32'(pend_g), 32'd1);
        cycle(1'b0, BASE + 32'h0, 32'h0, 1'b1);
        check("second commit reg0", live_g[0 +: 32], 32'haaaa_5555);
        cycle(1'b0, CTRL, 32'h0, 1'b0);
        check("apply_count two", rd_g, 32'h0000_0200);

        // Discard wins over commit (CTRL=3, then CTRL discard with apply_strobe)
        cycle(1'b1, BASE + 32'h8, 32'h77, 1'b0);
        cycle(1'b1, CTRL, 32'h3, 1'b0);
        check("discard no pulse", 32'(upd_g), 32'h0);
        check("discard pending", 32'(pend_g), 32'h0);
        cycle(1'b0, BASE + 32'h8, 32'h0, 1'b0);
        check("discard shadow", rd_g, 32'd3);
        cycle(1'b1, BASE + 32'h8, 32'h88, 1'b0);
        cycle(1'b1, CTRL, 32'h2, 1'b1);
        cycle(1'b0, CTRL, 32'h0, 1'b0);
        check("discard count kept", rd_g, 32'h0000_0200);
        check("discard live kept", live_g[64 +: 32], 32'd3);

        // 256 commits wrap apply_count, then an identical-value commit
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, BASE + 32'h0, 32'(i + 100), 1'b0);
            cycle(1'b0, BASE + 32'h0, 32'h0, 1'b1);
        end
        cycle(1'b0, CTRL, 32'h0, 1'b0);
        check("count wrap", rd_g, 32'h0);
        cycle(1'b1, BASE + 32'h0, 32'd355, 1'b0);
        cycle(1'b0, BASE + 32'h0, 32'h0, 1'b1);
        check("same value no pulse", 32'(upd_g), 32'h0);
        cycle(1'b0, CTRL, 32'h0, 1'b0);
        check("same value counted", rd_g, 32'h0000_0100);

        // Ungated: live follows on the next edge, then reset mid-sequence
        do_reset();
        cycle(1'b1, BASE + 32'hc, 32'h55, 1'b0);
        cycle(1'b0, BASE + 32'hc, 32'h0, 1'b0);
        check("ungated live reg3", live_u[96 +: 32], 32'h55);
        check("ungated pulse", 32'(upd_u), 32'b1000);
        check("ungated pending", 32'(pend_u), 32'h0);
        cycle(1'b1, BASE + 32'h0, 32'h1357_9bdf, 1'b1);
        do_reset();
        check("mid reset reg0", live_u[0 +: 32], 32'd1);
        check("mid reset reg3", live_u[96 +: 32], 32'd4);

        // Randomised traffic against the model
        for (int k = 0; k < 800; k++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 5)      a = BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(0, 3));
            else if (pick <= 7) a = CTRL + 32'($urandom_range(0, 3));
            else if (pick == 8) a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 59));
            else                a = BASE + 32'h104 + 32'($urandom_range(0, 255));
            d = (pick == 6 || pick == 7) ? 32'($urandom_range(0, 3)) : $urandom;
            cycle(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 3) == 0));
            if (k == 400) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
